// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared AXI interconnect types: W-channel FSM states and order-entry width helpers
package axi_ic_pkg;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_t;

    // Index width for a population of n, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Order entry packing is {master, slave, len}, master in the MSBs.
    function automatic int entry_w(input int m, input int s, input int len_w);
        return idx_w(m) + idx_w(s) + len_w;
    endfunction

    function automatic int entry_slave_lsb(input int len_w);
        return len_w;
    endfunction

    function automatic int entry_master_lsb(input int s, input int len_w);
        return idx_w(s) + len_w;
    endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous FIFO with registered full flag, pushes while full are dropped
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Occupancy after this cycle's accepted push/pop; simultaneous ones cancel.
    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; full tracks the new count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage has no reset; validity is governed by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/write_data_arbiter.sv
// rtl/write_data_arbiter.sv - in-order W channel scheduler; optional length check under W_LEN_CHECK_EN
module write_data_arbiter
    import axi_ic_pkg::*;
#(
    parameter int M         = 2,
    parameter int S         = 2,
    parameter int DEPTH     = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  aw_push,
    input  logic [idx_w(M)-1:0]   aw_master,
    input  logic [idx_w(S)-1:0]   aw_slave,
    input  logic [LEN_WIDTH-1:0]  aw_len,
    output logic                  aw_full,
    input  logic [M-1:0]          W_valid_f,
    input  logic [M-1:0]          W_last_f,
    output logic [M-1:0]          W_ready_f,
    output logic [M-1:0]          W_grant_f,
    output logic [S-1:0]          W_slave_valid_f,
    output logic [S-1:0]          W_slave_last_f,
    input  logic [S-1:0]          W_slave_ready_f,
    output logic [idx_w(M)-1:0]   W_master_sel,
    output logic                  err
);

    localparam int MW = idx_w(M);
    localparam int SW = idx_w(S);
    localparam int EW = entry_w(M, S, LEN_WIDTH);
    localparam int SL = entry_slave_lsb(LEN_WIDTH);
    localparam int ML = entry_master_lsb(S, LEN_WIDTH);

    w_state_t       state;
    w_state_t       state_next;
    logic [MW-1:0]  cur_master;
    logic [SW-1:0]  cur_slave;
    logic [EW-1:0]  q_wdata;
    logic [EW-1:0]  q_rdata;
    logic           q_empty;
    logic           q_pop;
    logic           beat;
    logic           fwd_last;
    logic           burst_done;
    logic           len_err;
    logic [MW-1:0]  hd_master;
    logic [SW-1:0]  hd_slave;

    assign q_wdata   = {aw_master, aw_slave, aw_len};
    assign hd_master = q_rdata[ML +: MW];
    assign hd_slave  = q_rdata[SL +: SW];

`ifdef W_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] cur_len;
    logic [LEN_WIDTH:0]   beat_cnt;
    logic                 at_len;

    assign at_len = (beat_cnt == {1'b0, cur_len});
`else
    logic unused_len;

    assign unused_len = ^q_rdata[LEN_WIDTH-1:0];
`endif

    fifo #(
        .DATA_WIDTH (EW),
        .DEPTH      (DEPTH)
    ) u_order_q (
        .clk   (clk),
        .clr   (clr),
        .push  (aw_push),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .empty (q_empty),
        .full  (aw_full)
    );

    // Next state plus handshake routing for the single master->slave pair owning W.
    always_comb begin
        state_next      = state;
        q_pop           = 1'b0;
        W_ready_f       = '0;
        W_grant_f       = '0;
        W_slave_valid_f = '0;
        W_slave_last_f  = '0;
        W_master_sel    = '0;
        beat            = 1'b0;
        fwd_last        = 1'b0;
        burst_done      = 1'b0;
        len_err         = 1'b0;
        case (state)
            W_IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    state_next = W_BURST;
                end
            end
            W_BURST: begin
                W_grant_f[cur_master]       = 1'b1;
                W_master_sel                = cur_master;
                fwd_last                    = W_last_f[cur_master];
                W_slave_valid_f[cur_slave]  = W_valid_f[cur_master];
                W_ready_f[cur_master]       = W_slave_ready_f[cur_slave];
                beat = W_valid_f[cur_master] & W_slave_ready_f[cur_slave];
`ifdef W_LEN_CHECK_EN
                // The expected final beat is always marked last to the slave.
                W_slave_last_f[cur_slave] = fwd_last | at_len;
                burst_done = beat & (fwd_last | at_len);
                len_err    = beat & (fwd_last ^ at_len);
`else
                W_slave_last_f[cur_slave] = fwd_last;
                burst_done = beat & fwd_last;
`endif
                if (burst_done) begin
                    state_next = W_IDLE;
                end
            end
            default: begin
                state_next = W_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= W_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the head entry as the burst owner when it is popped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_master <= '0;
            cur_slave  <= '0;
        end else if (q_pop) begin
            cur_master <= hd_master;
            cur_slave  <= hd_slave;
        end
    end

`ifdef W_LEN_CHECK_EN
    // Beat index within the burst, restarted on every new grant.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (q_pop) begin
            cur_len  <= q_rdata[LEN_WIDTH-1:0];
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // One-cycle error pulse on a last/length disagreement.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err <= 1'b0;
        end else begin
            err <= len_err;
        end
    end
`else
    assign err = len_err;
`endif

endmodule

// File: tb/tb_write_data_arbiter.sv
// tb/tb_write_data_arbiter.sv - table-driven and directed checks for write_data_arbiter
module tb_write_data_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       aw_push;
    logic [0:0] aw_master;
    logic [0:0] aw_slave;
    logic [7:0] aw_len;
    logic       aw_full;
    logic [1:0] W_valid_f;
    logic [1:0] W_last_f;
    logic [1:0] W_ready_f;
    logic [1:0] W_grant_f;
    logic [1:0] W_slave_valid_f;
    logic [1:0] W_slave_last_f;
    logic [1:0] W_slave_ready_f;
    logic [0:0] W_master_sel;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       p;
        logic       am;
        logic       asl;
        logic [7:0] al;
        logic [1:0] wv;
        logic [1:0] wl;
        logic [1:0] sr;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [36];

    write_data_arbiter #(.M(2), .S(2), .DEPTH(4), .LEN_WIDTH(8)) dut (
        .clk             (clk),
        .clr             (clr),
        .aw_push         (aw_push),
        .aw_master       (aw_master),
        .aw_slave        (aw_slave),
        .aw_len          (aw_len),
        .aw_full         (aw_full),
        .W_valid_f       (W_valid_f),
        .W_last_f        (W_last_f),
        .W_ready_f       (W_ready_f),
        .W_grant_f       (W_grant_f),
        .W_slave_valid_f (W_slave_valid_f),
        .W_slave_last_f  (W_slave_last_f),
        .W_slave_ready_f (W_slave_ready_f),
        .W_master_sel    (W_master_sel),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Expected output word: {full, wready, grant, svalid, slast, sel, err}
    function automatic logic [11:0] ex(input logic f, input logic [1:0] wr, input logic [1:0] gr,
                                       input logic [1:0] sv, input logic [1:0] sl, input logic sel,
                                       input logic e);
        return {f, wr, gr, sv, sl, sel, e};
    endfunction

    function automatic vec_t mk(input logic p, input logic am, input logic asl, input logic [7:0] al,
                                input logic [1:0] wv, input logic [1:0] wl, input logic [1:0] sr,
                                input logic [11:0] e);
        vec_t v;
        v.p = p; v.am = am; v.asl = asl; v.al = al;
        v.wv = wv; v.wl = wl; v.sr = sr; v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic p, input logic am, input logic asl, input logic [7:0] al,
                         input logic [1:0] wv, input logic [1:0] wl, input logic [1:0] sr);
        aw_push = p; aw_master = am; aw_slave = asl; aw_len = al;
        W_valid_f = wv; W_last_f = wl; W_slave_ready_f = sr;
    endtask

    task automatic check(input string name, input logic [11:0] e);
        logic [11:0] act;
        act = {aw_full, W_ready_f, W_grant_f, W_slave_valid_f, W_slave_last_f, W_master_sel, err};
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got full/wr/gr/sv/sl/sel/err=%b required %b", name, act, e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] Z = 12'h000;

    initial begin
        // Ordering, unused-master isolation, backpressure, fill/full/simultaneous push-pop.
        tbl[0]  = mk(1, 1, 0, 1, 2'b00, 2'b00, 2'b00, Z);
        tbl[1]  = mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[2]  = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, ex(0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 0));
        tbl[3]  = mk(0, 0, 0, 0, 2'b10, 2'b10, 2'b01, ex(0, 2'b10, 2'b10, 2'b01, 2'b01, 1, 0));
        tbl[4]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[5]  = mk(0, 0, 0, 0, 2'b11, 2'b01, 2'b10, ex(0, 2'b01, 2'b01, 2'b10, 2'b10, 0, 0));
        tbl[6]  = mk(0, 0, 0, 0, 2'b11, 2'b11, 2'b11, Z);
        tbl[7]  = mk(1, 0, 0, 3, 2'b00, 2'b00, 2'b00, Z);
        tbl[8]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[9]  = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[10] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[11] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[12] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, ex(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[13] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, ex(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[14] = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, ex(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0));
        tbl[15] = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b01, ex(0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0));
        tbl[16] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[17] = mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[18] = mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[19] = mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
        tbl[20] = mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
        tbl[21] = mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ex(0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
        tbl[22] = mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, ex(1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0));
        tbl[23] = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b01, ex(1, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0));
        tbl[24] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ex(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
        tbl[25] = mk(0, 0, 0, 0, 2'b10, 2'b10, 2'b10, ex(0, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0));
        tbl[26] = mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[27] = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b10, ex(0, 2'b01, 2'b01, 2'b10, 2'b10, 0, 0));
        tbl[28] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[29] = mk(0, 0, 0, 0, 2'b10, 2'b10, 2'b01, ex(0, 2'b10, 2'b10, 2'b01, 2'b01, 1, 0));
        tbl[30] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[31] = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b01, ex(0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0));
        tbl[32] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[33] = mk(0, 0, 0, 0, 2'b10, 2'b10, 2'b01, ex(0, 2'b10, 2'b10, 2'b01, 2'b01, 1, 0));
        tbl[34] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, Z);
        tbl[35] = mk(0, 0, 0, 0, 2'b11, 2'b11, 2'b11, Z);

        clr = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", Z);
        next_cycle();
        clr = 1'b0;

        for (int i = 0; i < 36; i++) begin
            drive(tbl[i].p, tbl[i].am, tbl[i].asl, tbl[i].al, tbl[i].wv, tbl[i].wl, tbl[i].sr);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].exp);
            next_cycle();
        end

        // Reset in the middle of M0->S1 (beat 2 of 4) with a second entry still queued.
        drive(1, 0, 1, 3, 2'b00, 2'b00, 2'b00);
        next_cycle();
        drive(1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        next_cycle();
        drive(0, 0, 0, 0, 2'b01, 2'b00, 2'b10);
        @(negedge clk);
        check("rst_beat0", ex(0, 2'b01, 2'b01, 2'b10, 2'b00, 0, 0));
        next_cycle();
        #2;
        clr = 1'b1;
        #1;
        check("rst_async", Z);
        next_cycle();
        check("rst_hold", Z);
        clr = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("rst_idle", Z);
        next_cycle();
        @(negedge clk);
        check("rst_q_empty", Z);
        next_cycle();
        drive(1, 1, 1, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("post_rst_push", Z);
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("post_rst_idle", Z);
        next_cycle();
        drive(0, 0, 0, 0, 2'b10, 2'b10, 2'b10);
        @(negedge clk);
        check("post_rst_grant", ex(0, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0));
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("post_rst_done", Z);
        next_cycle();

`ifdef W_LEN_CHECK_EN
        // len=3 but WLAST on beat 1: early end plus err pulse.
        drive(1, 0, 0, 3, 2'b00, 2'b00, 2'b00);
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        next_cycle();
        drive(0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        @(negedge clk);
        check("lc_early_b0", ex(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0));
        next_cycle();
        drive(0, 0, 0, 0, 2'b01, 2'b01, 2'b01);
        @(negedge clk);
        check("lc_early_b1", ex(0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0));
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("lc_early_err", ex(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        next_cycle();
        // len=1 and no WLAST on beat 1: forced last, err, back to idle.
        drive(1, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("lc_err_clear", Z);
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        next_cycle();
        drive(0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        @(negedge clk);
        check("lc_force_b0", ex(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0));
        next_cycle();
        @(negedge clk);
        check("lc_force_b1", ex(0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0));
        next_cycle();
        @(negedge clk);
        check("lc_force_err", ex(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("lc_force_idle", Z);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_data_arbiter.md
# write_data_arbiter

Schedules the AXI write-data (W) channel of the M×S interconnect. It records every write-address acceptance from the address arbiter in a global in-order queue. It grants the W channel to one master→slave pair at a time, in strict AW-acceptance order, so bursts never interleave. The block produces the handshake gating and mux selects only; the WDATA/WSTRB mux is external.

## Interface
Parameters:
- M, 2, number of masters
- S, 2, number of slaves
- DEPTH, 4, order-queue entries (power of two, ≥2)
- LEN_WIDTH, 8, AWLEN width

Ports:
- clk  in  1  clock
- clr  in  1  asynchronous, active-high reset
- aw_push  in  1  AW accepted by address arbiter this cycle
- aw_master  in  $clog2(M)  master of accepted AW
- aw_slave  in  $clog2(S)  decoded slave of accepted AW
- aw_len  in  LEN_WIDTH  AWLEN of accepted AW (beats−1)
- aw_full  out  1  queue full; address arbiter must not push
- W_valid_f  in  M  master WVALID
- W_last_f  in  M  master WLAST
- W_ready_f  out  M  WREADY back to masters
- W_grant_f  out  M  one-hot master owning W channel
- W_slave_valid_f  out  S  WVALID to slaves
- W_slave_last_f  out  S  WLAST to slaves
- W_slave_ready_f  in  S  slave WREADY
- W_master_sel  out  $clog2(M)  data-mux select (current master)
- err  out  1  length-mismatch pulse (W_LEN_CHECK_EN only)

## Operation
- Queue entry = {master, slave, len}. aw_push writes the entry; aw_push while aw_full is ignored (no write, no state change).
- FSM states: IDLE, BURST.
- IDLE: all grants/valids/readies 0. If queue non-empty: latch head into cur_master/cur_slave/cur_len, pop, clear beat counter, → BURST.
- BURST:
  - W_grant_f[cur_master]=1; W_master_sel=cur_master.
  - W_slave_valid_f[cur_slave]=W_valid_f[cur_master], W_slave_last_f[cur_slave]=W_last_f[cur_master]; W_ready_f[cur_master]=W_slave_ready_f[cur_slave]; all other bits 0.
  - Beat = valid & ready on that pair. Beat with last → IDLE.
- Push and pop in the same cycle are both honoured; count is unchanged. A pop from the full state deasserts aw_full next cycle.
- Count is clog2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.
- Reset mid-burst: the FSM returns to IDLE, the queue empties, and the in-flight burst is abandoned. All outputs are 0 during and after reset (aw_full=0, err=0, W_master_sel=0).

## Timing
- aw_push at cycle n into empty queue → IDLE sees non-empty at n+1 → grant asserted at n+2.
- Last beat at cycle k → BURST exits; next queued burst is granted at k+2 (one IDLE bubble).
- Gating outputs are combinational from registered state and current valid/ready (no added beat latency). A single-beat burst completes in its first BURST cycle.
- aw_full is registered from count (== DEPTH).

## Configuration
- W_LEN_CHECK_EN defined: a beat counter (LEN_WIDTH+1 bits) counts beats in BURST.
  - Last on beat index ≠ cur_len → err pulses 1 cycle, burst ends.
  - Beat index == cur_len without last → err pulses 1 cycle and the burst is force-terminated. W_slave_last_f is asserted for that beat.
- Undefined: aw_len ignored, no counter, err tied 0, termination solely on WLAST.

## Structure
- Shared package axi_ic_pkg: state encodings (W_IDLE, W_BURST) and the order-entry field widths/packing helper.
- One sub-module: fifo (existing codebase FIFO, DATA_WIDTH=$clog2(M)+$clog2(S)+LEN_WIDTH, DEPTH=DEPTH) holds the order queue. The FSM, routing and counter live in write_data_arbiter.

## Test plan
- Reset: assert clr mid-burst (M0→S1, beat 2 of 4) → all outputs 0 next edge, queue empty, new push granted 2 cycles after push.
- Ordering: push (M1,S0,len 1) then (M0,S1,len 0) → M1→S0 two beats complete, W_grant_f=01 at last+2, M0 single beat forwarded to S1.
- Backpressure: W_slave_ready_f[0]=0 for 3 cycles during M0→S0 burst → W_ready_f[0]=0 those cycles, beat count unchanged, no premature exit.
- Full/simultaneous: push DEPTH entries → aw_full=1; extra push ignored; push+last-beat pop same cycle → count stays DEPTH−1 after next pop cycle, no entry lost.
- W_LEN_CHECK_EN: len=3, master asserts WLAST on beat 1 → err=1 one cycle, burst ends; len=1, no WLAST on beat 1 → err=1, W_slave_last_f forced 1, FSM → IDLE.
- Unused masters: W_valid_f on non-granted master → its W_ready_f stays 0, no slave valid asserted.
